// File: rtl/softmax_in_buffer.sv
// softmax_in_buffer: input buffer and sequencer feeding the softmax engine
// Purpose: holds the vector loaded from a host beat stream, serves three
//    independent synchronous read ports to the engine, and sequences the
//    engine through init/start/done once a vector has been loaded.
// Ports:
//    clk, reset        clock, synchronous active-high reset
//    cmd_go, cfg_base  begin a load at cfg_base (IDLE only)
//    wr_valid/ready/data/last  host beat stream into the buffer
//    addr/inp, sub0_inp_addr/sub0_inp, sub1_inp_addr/sub1_inp  engine read ports
//    start_addr, end_addr, init, start, sm_done  engine handshake
//    busy, irq, ovf    status: not idle, completion pulse, load overflow (sticky)
//    rd_err            only with SOFTMAX_INBUF_RDCHK_EN: sticky out-of-range read flag
// Build option: define SOFTMAX_INBUF_RDCHK_EN to zero out-of-range reads while busy
//    and add the rd_err output.
module softmax_in_buffer #(
   parameter int DATAWIDTH = 16,
   parameter int NUM = 4,
   parameter int ADDRSIZE = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_go,
   input  logic [ADDRSIZE-1:0]       cfg_base,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [DATAWIDTH*NUM-1:0]  wr_data,
   input  logic                      wr_last,
   input  logic [ADDRSIZE-1:0]       addr,
   output logic [DATAWIDTH*NUM-1:0]  inp,
   input  logic [ADDRSIZE-1:0]       sub0_inp_addr,
   output logic [DATAWIDTH*NUM-1:0]  sub0_inp,
   input  logic [ADDRSIZE-1:0]       sub1_inp_addr,
   output logic [DATAWIDTH*NUM-1:0]  sub1_inp,
   output logic [ADDRSIZE-1:0]       start_addr,
   output logic [ADDRSIZE-1:0]       end_addr,
   output logic                      init,
   output logic                      start,
   input  logic                      sm_done,
   output logic                      busy,
   output logic                      irq,
`ifdef SOFTMAX_INBUF_RDCHK_EN
   output logic                      rd_err,
`endif
   output logic                      ovf
);
   localparam int W = DATAWIDTH*NUM;
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, INIT = 3'd2, START = 3'd3, RUN = 3'd4;
   logic [W-1:0] mem [0:(1<<ADDRSIZE)-1];
   logic [2:0] state_q, state_d;
   logic [ADDRSIZE-1:0] wptr_q, wptr_d, start_addr_q, start_addr_d, end_addr_q, end_addr_d;
   logic ovf_q, ovf_d, irq_q, irq_d, done_prev_q, we;
   logic [W-1:0] inp_q, inp_d, sub0_q, sub0_d, sub1_q, sub1_d;
   assign wr_ready = state_q == LOAD;
   assign init = state_q == INIT;
   assign start = state_q == START;
   assign busy = state_q != IDLE;
   assign irq = irq_q;
   assign ovf = ovf_q;
   assign start_addr = start_addr_q;
   assign end_addr = end_addr_q;
   assign inp = inp_q;
   assign sub0_inp = sub0_q;
   assign sub1_inp = sub1_q;
   always_comb begin
      state_d = state_q;
      wptr_d = wptr_q;
      start_addr_d = start_addr_q;
      end_addr_d = end_addr_q;
      ovf_d = ovf_q;
      irq_d = 1'b0;
      we = 1'b0;
      case (state_q)
         IDLE: if (cmd_go) begin
            start_addr_d = cfg_base;
            wptr_d = cfg_base;
            ovf_d = 1'b0;
            state_d = LOAD;
         end
         LOAD: if (wr_valid) begin
            we = 1'b1;
            // The top word terminates the load; the pointer never wraps.
            if (wr_last || &wptr_q) begin
               end_addr_d = wptr_q;
               ovf_d = !wr_last;
               state_d = INIT;
            end else wptr_d = wptr_q + 1'b1;
         end
         INIT: state_d = START;
         START: state_d = RUN;
         RUN: if (sm_done && !done_prev_q) begin
            irq_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef SOFTMAX_INBUF_RDCHK_EN
   logic rd_err_q, rd_err_d, oob0, oob1, oob2;
   assign oob0 = busy && (addr < start_addr_q || addr > end_addr_q);
   assign oob1 = busy && (sub0_inp_addr < start_addr_q || sub0_inp_addr > end_addr_q);
   assign oob2 = busy && (sub1_inp_addr < start_addr_q || sub1_inp_addr > end_addr_q);
   assign rd_err = rd_err_q;
   always_comb begin
      rd_err_d = (state_q == IDLE && cmd_go) ? 1'b0 : rd_err_q | oob0 | oob1 | oob2;
      inp_d = oob0 ? '0 : mem[addr];
      sub0_d = oob1 ? '0 : mem[sub0_inp_addr];
      sub1_d = oob2 ? '0 : mem[sub1_inp_addr];
   end
   always_ff @(posedge clk) rd_err_q <= reset ? 1'b0 : rd_err_d;
`else
   always_comb begin
      inp_d = mem[addr];
      sub0_d = mem[sub0_inp_addr];
      sub1_d = mem[sub1_inp_addr];
   end
`endif
   // Buffer contents survive reset; a write suppressed by reset is simply dropped.
   always_ff @(posedge clk) if (we && !reset) mem[wptr_q] <= wr_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q <= '0;
         start_addr_q <= '0;
         end_addr_q <= '0;
         ovf_q <= 1'b0;
         irq_q <= 1'b0;
         done_prev_q <= 1'b0;
         inp_q <= '0;
         sub0_q <= '0;
         sub1_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q <= wptr_d;
         start_addr_q <= start_addr_d;
         end_addr_q <= end_addr_d;
         ovf_q <= ovf_d;
         irq_q <= irq_d;
         done_prev_q <= sm_done;
         inp_q <= inp_d;
         sub0_q <= sub0_d;
         sub1_q <= sub1_d;
      end
   end
endmodule

// File: tb/tb_softmax_in_buffer.sv
// tb_softmax_in_buffer: directed self-checking bench for softmax_in_buffer
module tb_softmax_in_buffer;
   logic clk = 0, reset = 1, cmd_go = 0, wr_valid = 0, wr_last = 0, sm_done = 0;
   logic [7:0] cfg_base = 0, addr = 0, sub0_inp_addr = 0, sub1_inp_addr = 0;
   logic [63:0] wr_data = 0;
   logic wr_ready, init, start, busy, irq, ovf;
   logic [63:0] inp, sub0_inp, sub1_inp;
   logic [7:0] start_addr, end_addr;
`ifdef SOFTMAX_INBUF_RDCHK_EN
   logic rd_err;
`endif
   int n_chk = 0, n_fail = 0;
   logic [63:0] b [4] = '{64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
                          64'h0009_000A_000B_000C, 64'h000D_000E_000F_0010};
   logic [63:0] o [6] = '{64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                          64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0005};
   logic [63:0] r [3] = '{64'h1111_0000_0000_0010, 64'h1111_0000_0000_0011, 64'h2222_0000_0000_0020};
   logic [63:0] c [4] = '{64'h3333_0000_0000_0010, 64'h3333_0000_0000_0011,
                          64'h3333_0000_0000_0012, 64'h3333_0000_0000_0013};

   softmax_in_buffer dut (
      .clk(clk), .reset(reset), .cmd_go(cmd_go), .cfg_base(cfg_base),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
      .addr(addr), .inp(inp), .sub0_inp_addr(sub0_inp_addr), .sub0_inp(sub0_inp),
      .sub1_inp_addr(sub1_inp_addr), .sub1_inp(sub1_inp),
      .start_addr(start_addr), .end_addr(end_addr), .init(init), .start(start),
      .sm_done(sm_done), .busy(busy), .irq(irq),
`ifdef SOFTMAX_INBUF_RDCHK_EN
      .rd_err(rd_err),
`endif
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) tick();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_chk++; if ({wr_ready, init, start, irq, ovf} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {wr_ready, init, start, irq, ovf}); end
      n_chk++; if ({start_addr, end_addr} !== 16'h0) begin n_fail++; $display("FAIL reset_addrs: got %h want 0000", {start_addr, end_addr}); end
      n_chk++; if ({inp, sub0_inp, sub1_inp} !== 192'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h %h want 0", inp, sub0_inp, sub1_inp); end
      reset = 0;
      tick();
   endtask

   task automatic test_load();
      cmd_go = 1; cfg_base = 8'h00;
      tick();
      cmd_go = 0;
      n_chk++; if ({wr_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL load_enter: got %b want 11", {wr_ready, busy}); end
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1; wr_data = b[i]; wr_last = (i == 3);
         tick();
      end
      wr_valid = 0; wr_last = 0;
      n_chk++; if ({init, start} !== 2'b10) begin n_fail++; $display("FAIL load_init: got init/start %b want 10", {init, start}); end
      n_chk++; if (end_addr !== 8'h03) begin n_fail++; $display("FAIL load_end_addr: got %h want 03", end_addr); end
      n_chk++; if (start_addr !== 8'h00) begin n_fail++; $display("FAIL load_start_addr: got %h want 00", start_addr); end
      n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop: got %b want 0", wr_ready); end
      tick();
      n_chk++; if ({init, start} !== 2'b01) begin n_fail++; $display("FAIL load_start: got init/start %b want 01", {init, start}); end
      tick();
      n_chk++; if ({init, start, busy} !== 3'b001) begin n_fail++; $display("FAIL load_run: got init/start/busy %b want 001", {init, start, busy}); end
   endtask

   task automatic test_read();
      addr = 8'h02; sub0_inp_addr = 8'h01; sub1_inp_addr = 8'h00;
      tick();
      n_chk++; if (inp !== b[2]) begin n_fail++; $display("FAIL read_inp: got %h want %h", inp, b[2]); end
      n_chk++; if (sub0_inp !== b[1]) begin n_fail++; $display("FAIL read_sub0: got %h want %h", sub0_inp, b[1]); end
      n_chk++; if (sub1_inp !== b[0]) begin n_fail++; $display("FAIL read_sub1: got %h want %h", sub1_inp, b[0]); end
   endtask

   task automatic test_done();
      int irq_cnt = 0;
      cmd_go = 1; cfg_base = 8'h55;
      tick();
      cmd_go = 0;
      n_chk++; if ({busy, wr_ready} !== 2'b10) begin n_fail++; $display("FAIL run_cmd_go_ignored: got busy/ready %b want 10", {busy, wr_ready}); end
      n_chk++; if (start_addr !== 8'h00) begin n_fail++; $display("FAIL run_start_addr_hold: got %h want 00", start_addr); end
      sm_done = 1;
      repeat (5) begin
         tick();
         irq_cnt += int'(irq);
      end
      n_chk++; if (irq_cnt != 1) begin n_fail++; $display("FAIL done_irq_count: got %0d want 1", irq_cnt); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b want 0", busy); end
      n_chk++; if (end_addr !== 8'h03) begin n_fail++; $display("FAIL done_end_hold: got %h want 03", end_addr); end
      sm_done = 0;
      tick();
   endtask

   task automatic test_ovf();
      cmd_go = 1; cfg_base = 8'hFC;
      tick();
      cmd_go = 0;
      wr_valid = 1; wr_last = 0;
      for (int i = 0; i < 6; i++) begin
         wr_data = o[i];
         n_chk++; if (wr_ready !== (i < 4)) begin n_fail++; $display("FAIL ovf_ready_%0d: got %b want %b", i, wr_ready, i < 4); end
         tick();
         if (i == 3) begin
            n_chk++; if (init !== 1'b1) begin n_fail++; $display("FAIL ovf_init: got %b want 1", init); end
         end
      end
      wr_valid = 0;
      n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
      n_chk++; if ({start_addr, end_addr} !== 16'hFCFF) begin n_fail++; $display("FAIL ovf_addrs: got %h want fcff", {start_addr, end_addr}); end
      addr = 8'hFF; sub0_inp_addr = 8'hFE; sub1_inp_addr = 8'hFC;
      tick();
      n_chk++; if (inp !== o[3]) begin n_fail++; $display("FAIL ovf_top_word: got %h want %h", inp, o[3]); end
      n_chk++; if (sub0_inp !== o[2]) begin n_fail++; $display("FAIL ovf_word_fe: got %h want %h", sub0_inp, o[2]); end
      sm_done = 1;
      tick();
      n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b want 1", irq); end
      sm_done = 0;
      addr = 8'h00;
      tick();
      n_chk++; if (inp !== b[0]) begin n_fail++; $display("FAIL ovf_no_wrap: got %h want %h", inp, b[0]); end
      n_chk++; if ({ovf, busy} !== 2'b10) begin n_fail++; $display("FAIL ovf_sticky: got ovf/busy %b want 10", {ovf, busy}); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      cmd_go = 1; cfg_base = 8'h10;
      tick();
      cmd_go = 0;
      n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL cmd_go_clears_ovf: got %b want 0", ovf); end
      wr_valid = 1; wr_data = r[0];
      tick();
      wr_data = r[1];
      tick();
      wr_valid = 0; reset = 1;
      tick();
      n_chk++; if ({busy, wr_ready, ovf} !== 3'b000) begin n_fail++; $display("FAIL midrst_state: got busy/ready/ovf %b want 000", {busy, wr_ready, ovf}); end
      n_chk++; if ({start_addr, end_addr, inp} !== 80'h0) begin n_fail++; $display("FAIL midrst_outs: got %h %h %h want 0", start_addr, end_addr, inp); end
      reset = 0;
      repeat (3) begin
         pulses += int'(init) + int'(start) + int'(irq);
         tick();
      end
      n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d want 0", pulses); end
      cmd_go = 1; cfg_base = 8'h20;
      tick();
      cmd_go = 0;
      n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_reload: got %b want 1", wr_ready); end
      wr_valid = 1; wr_data = r[2]; wr_last = 1;
      tick();
      wr_valid = 0; wr_last = 0;
      n_chk++; if ({init, start_addr, end_addr} !== 17'h1_2020) begin n_fail++; $display("FAIL midrst_single_beat: got %h want 12020", {init, start_addr, end_addr}); end
      repeat (2) tick();
      sm_done = 1;
      tick();
      n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL midrst_irq: got %b want 1", irq); end
      sm_done = 0;
      tick();
   endtask

   task automatic test_rdchk();
      addr = 8'h10; sub0_inp_addr = 8'h11; sub1_inp_addr = 8'h12;
      cmd_go = 1; cfg_base = 8'h10;
      tick();
      cmd_go = 0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1; wr_data = c[i]; wr_last = (i == 3);
         tick();
         if (i == 0) begin
            n_chk++; if (inp !== r[0]) begin n_fail++; $display("FAIL rw_collision_old: got %h want %h", inp, r[0]); end
         end
      end
      wr_valid = 0; wr_last = 0;
      n_chk++; if (end_addr !== 8'h13) begin n_fail++; $display("FAIL rdchk_end_addr: got %h want 13", end_addr); end
      repeat (2) tick();
`ifdef SOFTMAX_INBUF_RDCHK_EN
      n_chk++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rdchk_err_clear: got %b want 0", rd_err); end
`endif
      addr = 8'h20;
      tick();
      n_chk++; if (sub0_inp !== c[1]) begin n_fail++; $display("FAIL rdchk_in_range: got %h want %h", sub0_inp, c[1]); end
`ifdef SOFTMAX_INBUF_RDCHK_EN
      n_chk++; if (inp !== 64'h0) begin n_fail++; $display("FAIL rdchk_oob_zero: got %h want 0", inp); end
      n_chk++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL rdchk_err_set: got %b want 1", rd_err); end
`else
      n_chk++; if (inp !== r[2]) begin n_fail++; $display("FAIL rdchk_oob_stored: got %h want %h", inp, r[2]); end
`endif
      sm_done = 1;
      tick();
      sm_done = 0;
      tick();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdchk_finish: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_read();
      test_done();
      test_ovf();
      test_reset_mid();
      test_rdchk();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
